// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared definitions for the two-requester divider arbiter.
//   - DIV_WIDTH : default operand / quotient / remainder width
//   - NREQ      : number of requesters sharing the divider
//   - div_state_t : arbiter FSM encoding (IDLE, SUB, RESP)
//   - all_ones() : helper returning the all-ones quotient used on divide-by-zero
// Optional feature macro: DIV_ARB_EARLY_EXIT_EN (used by div_arbiter).
// ---------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_WIDTH = 4;
    localparam int NREQ      = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_RESP = 2'd2
    } div_state_t;

    // Quotient reported for a zero divisor.
    function automatic logic [DIV_WIDTH-1:0] all_ones();
        return {DIV_WIDTH{1'b1}};
    endfunction

endpackage

// File: rtl/div_core.sv
// ---------------------------------------------------------------------------
// div_core
// Restoring-free, subtract-per-cycle unsigned divider datapath.
// Holds the running remainder, the captured divisor and the quotient count.
// The sequencing (when to load, when to step, when to stop) is owned by the
// instantiating FSM.
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   i_load    : capture i_num / i_den, clear quotient
//   i_num     : dividend to load
//   i_den     : divisor to load
//   i_step    : perform one subtract step (only issued while o_ge is high)
//   o_ge      : running remainder >= captured divisor
//   o_quot    : quotient accumulated so far
//   o_rem     : running remainder
// ---------------------------------------------------------------------------
module div_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_num,
    input  logic [WIDTH-1:0] i_den,
    input  logic             i_step,
    output logic             o_ge,
    output logic [WIDTH-1:0] o_quot,
    output logic [WIDTH-1:0] o_rem
);

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_den;
    logic [WIDTH-1:0] r_quot;

    // Subtraction is only ever applied when r_rem >= r_den, so it cannot
    // underflow; the quotient peaks at 2^WIDTH-1 (den=1), so it cannot wrap.
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quot_next;

    assign o_ge        = (r_rem >= r_den);
    assign w_rem_next  = r_rem - r_den;
    assign w_quot_next = r_quot + {{(WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem  <= '0;
            r_den  <= '0;
            r_quot <= '0;
        end else if (i_load) begin
            r_rem  <= i_num;
            r_den  <= i_den;
            r_quot <= '0;
        end else if (i_step) begin
            r_rem  <= w_rem_next;
            r_quot <= w_quot_next;
        end
    end

    assign o_quot = r_quot;
    assign o_rem  = r_rem;

endmodule

// File: rtl/div_arbiter.sv
// ---------------------------------------------------------------------------
// div_arbiter
// Shares one iterative subtract-based divider between two requesters.
// Round-robin grant in IDLE, one operation in flight, single response
// channel with valid/ready hold semantics.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   req_valid  : per-requester operation pending
//   req_num    : dividends, requester i at [i*WIDTH +: WIDTH]
//   req_den    : divisors, same packing
//   req_ready  : per-requester accept strobe (combinational, IDLE only)
//   rsp_valid  : response held valid until rsp_ready
//   rsp_ready  : consumer takes the response
//   rsp_id     : requester owning the response
//   rsp_quot   : quotient (all ones on divide-by-zero)
//   rsp_rem    : remainder (dividend on divide-by-zero)
//   rsp_err    : divide-by-zero flag
//   busy       : high whenever the FSM is not in IDLE
// Optional feature macro: DIV_ARB_EARLY_EXIT_EN
//   When defined, num<den (den!=0) is answered straight from IDLE with
//   quot=0, rem=num, saving the single compare cycle in SUB.
// ---------------------------------------------------------------------------
module div_arbiter
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_num,
    input  logic [NREQ*WIDTH-1:0] req_den,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [WIDTH-1:0]      rsp_quot,
    output logic [WIDTH-1:0]      rsp_rem,
    output logic                  rsp_err,
    output logic                  busy
);

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    div_state_t       r_state;
    logic             r_last_grant;
    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_quot;
    logic [WIDTH-1:0] r_rsp_rem;
    logic             r_rsp_err;
    logic             r_busy;

    // -----------------------------------------------------------------------
    // Operand unpacking
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] w_num_arr [NREQ];
    logic [WIDTH-1:0] w_den_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_num_arr[gi] = req_num[gi*WIDTH +: WIDTH];
            assign w_den_arr[gi] = req_den[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Grant: only in IDLE. On a tie the requester that did not win last
    // time gets it; r_last_grant resets to 1 so requester 0 wins first.
    // -----------------------------------------------------------------------
    logic             w_idle;
    logic             w_accept;
    logic             w_grant;
    logic [WIDTH-1:0] w_sel_num;
    logic [WIDTH-1:0] w_sel_den;
    logic             w_den_zero;
    logic             w_num_lt_den;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_accept = w_idle && (|req_valid);

    always_comb begin
        w_grant = 1'b0;
        if (req_valid == 2'b11) begin
            w_grant = ~r_last_grant;
        end else if (req_valid[1]) begin
            w_grant = 1'b1;
        end
    end

    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = w_accept && (w_grant == gi[0]);
        end
    endgenerate

    assign w_sel_num    = w_num_arr[w_grant];
    assign w_sel_den    = w_den_arr[w_grant];
    assign w_den_zero   = (w_sel_den == '0);
    assign w_num_lt_den = (w_sel_num < w_sel_den);

    // -----------------------------------------------------------------------
    // Divider datapath
    // -----------------------------------------------------------------------
    logic             w_core_ge;
    logic             w_core_step;
    logic [WIDTH-1:0] w_core_quot;
    logic [WIDTH-1:0] w_core_rem;

    assign w_core_step = (r_state == ST_SUB) && w_core_ge;

    div_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_accept),
        .i_num  (w_sel_num),
        .i_den  (w_sel_den),
        .i_step (w_core_step),
        .o_ge   (w_core_ge),
        .o_quot (w_core_quot),
        .o_rem  (w_core_rem)
    );

    // -----------------------------------------------------------------------
    // Control FSM with registered response outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_quot   <= '0;
            r_rsp_rem    <= '0;
            r_rsp_err    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_last_grant <= w_grant;
                        r_rsp_id     <= w_grant;
                        r_busy       <= 1'b1;
                        if (w_den_zero) begin
                            r_rsp_err   <= 1'b1;
                            r_rsp_quot  <= all_ones();
                            r_rsp_rem   <= w_sel_num;
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_RESP;
`ifdef DIV_ARB_EARLY_EXIT_EN
                        end else if (w_num_lt_den) begin
                            r_rsp_err   <= 1'b0;
                            r_rsp_quot  <= '0;
                            r_rsp_rem   <= w_sel_num;
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_RESP;
`endif
                        end else begin
                            r_state <= ST_SUB;
                        end
                    end
                end

                ST_SUB: begin
                    // The core steps on its own while ge holds; the first
                    // failing compare ends the division.
                    if (!w_core_ge) begin
                        r_rsp_quot  <= w_core_quot;
                        r_rsp_rem   <= w_core_rem;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    // The early-exit compare is only consumed when the feature is built in.
    logic w_unused;
    assign w_unused = w_num_lt_den;

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_quot  = r_rsp_quot;
    assign rsp_rem   = r_rsp_rem;
    assign rsp_err   = r_rsp_err;
    assign busy      = r_busy;

endmodule

// File: tb/tb_div_arbiter.sv
module tb_div_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] req_valid;
    logic [7:0] req_num;
    logic [7:0] req_den;
    logic [1:0] req_ready;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [3:0] rsp_quot;
    logic [3:0] rsp_rem;
    logic       rsp_err;
    logic       busy;

    int total;
    int bad;

    div_arbiter #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_num   (req_num),
        .req_den   (req_den),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_quot  (rsp_quot),
        .rsp_rem   (rsp_rem),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an operation, wait for its accept, then count cycles until
    // rsp_valid. lat = index of the first RESP cycle, accept cycle = 0.
    task automatic issue(input int id, input logic [3:0] num, input logic [3:0] den,
                         output int lat, output bit ok);
        int n;
        ok = 1'b0;
        lat = 0;
        req_num[id*4 +: 4] = num;
        req_den[id*4 +: 4] = den;
        req_valid[id] = 1'b1;
        n = 0;
        #1;
        while (!req_ready[id] && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (!req_ready[id]) begin
            bad++;
            $display("FAIL accept_timeout id=%0d req_ready=%b required bit set", id, req_ready);
            req_valid[id] = 1'b0;
            return;
        end
        tick();
        req_valid[id] = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 30) begin
            tick();
            lat++;
        end
        total++;
        if (!rsp_valid) begin
            bad++;
            $display("FAIL rsp_timeout id=%0d num=%0d den=%0d", id, num, den);
            return;
        end
        ok = 1'b1;
        $display("op id=%0d num=%0d den=%0d lat=%0d quot=%0d rem=%0d err=%0d rsp_id=%0d",
                 id, num, den, lat, rsp_quot, rsp_rem, rsp_err, rsp_id);
    endtask

    task automatic check_rsp(input string name, input int lat, input int exp_lat,
                             input logic [3:0] q, input logic [3:0] r,
                             input logic e, input logic id);
        total++;
        if (lat != exp_lat) begin
            bad++;
            $display("FAIL %s_latency got=%0d want=%0d", name, lat, exp_lat);
        end
        total++;
        if ({rsp_quot, rsp_rem, rsp_err, rsp_id} !== {q, r, e, id}) begin
            bad++;
            $display("FAIL %s_result got q=%0d r=%0d e=%b id=%b want q=%0d r=%0d e=%b id=%b",
                     name, rsp_quot, rsp_rem, rsp_err, rsp_id, q, r, e, id);
        end
    endtask

    task automatic take_rsp(input string name);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        total++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_release got valid=%b busy=%b want 0 0", name, rsp_valid, busy);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if ({rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_err, busy, req_ready} !== 13'b0) begin
            bad++;
            $display("FAIL reset_outputs got v=%b id=%b q=%0d r=%0d e=%b busy=%b rdy=%b want all 0",
                     rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_err, busy, req_ready);
        end
        // Tie right after reset goes to requester 0; dropping valid before
        // the edge means nothing is accepted.
        req_valid = 2'b11;
        #1;
        total++;
        if (req_ready !== 2'b01) begin
            bad++;
            $display("FAIL reset_first_tie got=%b want=01", req_ready);
        end
        req_valid = 2'b00;
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL dropped_valid_busy got=%b want=0", busy);
        end
        $display("reset checks done");
    endtask

    task automatic test_basic();
        int lat;
        bit ok;
        issue(0, 4'd13, 4'd4, lat, ok);
        if (ok) begin
            check_rsp("div_13_4", lat, 5, 4'd3, 4'd1, 1'b0, 1'b0);
            take_rsp("div_13_4");
        end
    endtask

    task automatic test_div_zero();
        int lat;
        bit ok;
        issue(1, 4'd9, 4'd0, lat, ok);
        if (ok) begin
            check_rsp("div_zero", lat, 1, 4'd15, 4'd9, 1'b1, 1'b1);
            take_rsp("div_zero");
        end
    endtask

    task automatic test_round_robin();
        int grants[$];
        int ids[$];
        int n;
        apply_reset();
        req_num = {4'd6, 4'd6};
        req_den = {4'd3, 4'd3};
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        #1;
        for (int c = 0; c < 60 && grants.size() < 4; c++) begin
            if (req_ready == 2'b01) grants.push_back(0);
            else if (req_ready == 2'b10) grants.push_back(1);
            if (rsp_valid) ids.push_back(int'(rsp_id));
            tick();
        end
        req_valid = 2'b00;
        n = 0;
        while (busy && n < 30) begin
            if (rsp_valid) ids.push_back(int'(rsp_id));
            tick();
            n++;
        end
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= grants.size() || grants[i] != (i % 2)) begin
                bad++;
                $display("FAIL rr_grant_%0d got=%0d want=%0d", i,
                         (i < grants.size()) ? grants[i] : -1, i % 2);
            end
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (i >= ids.size() || ids[i] != (i % 2)) begin
                bad++;
                $display("FAIL rr_rsp_id_%0d got=%0d want=%0d", i,
                         (i < ids.size()) ? ids[i] : -1, i % 2);
            end
        end
        $display("round robin grants observed=%0d responses=%0d", grants.size(), ids.size());
    endtask

    task automatic test_hold();
        int lat;
        bit ok;
        issue(0, 4'd15, 4'd1, lat, ok);
        if (!ok) return;
        check_rsp("div_15_1", lat, 17, 4'd15, 4'd0, 1'b0, 1'b0);
        req_num[7:4] = 4'd8;
        req_den[7:4] = 4'd2;
        req_valid[1] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            total++;
            if ({rsp_valid, rsp_quot, rsp_rem, rsp_err, rsp_id, req_ready} !== {1'b1, 4'd15, 4'd0, 1'b0, 1'b0, 2'b00}) begin
                bad++;
                $display("FAIL hold_cycle_%0d got v=%b q=%0d r=%0d e=%b id=%b rdy=%b want 1 15 0 0 0 00",
                         c, rsp_valid, rsp_quot, rsp_rem, rsp_err, rsp_id, req_ready);
            end
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        total++;
        if (req_ready !== 2'b10 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL hold_release got rdy=%b valid=%b want 10 0", req_ready, rsp_valid);
        end
        req_valid = 2'b00;
        tick();
        $display("hold checks done");
    endtask

    task automatic test_small_num();
        int lat;
        bit ok;
        int exp_lat;
`ifdef DIV_ARB_EARLY_EXIT_EN
        exp_lat = 1;
`else
        exp_lat = 2;
`endif
        issue(1, 4'd2, 4'd7, lat, ok);
        if (ok) begin
            check_rsp("div_2_7", lat, exp_lat, 4'd0, 4'd2, 1'b0, 1'b1);
            take_rsp("div_2_7");
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit ok;
        int seen;
        req_num[3:0] = 4'd15;
        req_den[3:0] = 4'd1;
        req_valid[0] = 1'b1;
        #1;
        total++;
        if (req_ready !== 2'b01) begin
            bad++;
            $display("FAIL midrst_accept got=%b want=01", req_ready);
        end
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_err, busy} !== 11'b0) begin
            bad++;
            $display("FAIL midrst_outputs got v=%b id=%b q=%0d r=%0d e=%b busy=%b want all 0",
                     rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_err, busy);
        end
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (rsp_valid || busy) seen++;
            tick();
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL midrst_no_rsp active_cycles=%0d want=0", seen);
        end
        issue(0, 4'd7, 4'd2, lat, ok);
        if (ok) begin
            check_rsp("after_rst_7_2", lat, 5, 4'd3, 4'd1, 1'b0, 1'b0);
            take_rsp("after_rst_7_2");
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        req_valid = 2'b00;
        req_num = '0;
        req_den = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_basic();
        test_div_zero();
        test_round_robin();
        test_hold();
        test_small_num();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
